// File: rtl/fabric_ingress_arbiter.sv
// fabric_ingress_arbiter: frame-granular round-robin ingress arbiter; stall watchdog with ABORT enabled by FABRIC_ARB_WATCHDOG_EN
module fabric_ingress_arbiter #(
    parameter int NUM_PORTS = 24,
    parameter int DATA_WIDTH = 32,
`ifdef FABRIC_ARB_WATCHDOG_EN
    parameter int TIMEOUT = 4096,
`endif
    localparam int PORT_BITS = $clog2(NUM_PORTS)
) (
    input  logic                            clk_fabric,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            frame_ready,
    input  logic [NUM_PORTS-1:0]            in_valid,
    input  logic [NUM_PORTS-1:0]            in_last,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    output logic [NUM_PORTS-1:0]            in_ready,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_last,
    output logic                            out_abort,
    output logic [PORT_BITS-1:0]            out_port,
    output logic                            busy
);
`ifdef FABRIC_ARB_WATCHDOG_EN
    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;
`else
    typedef enum logic {IDLE, BUSY} state_t;
`endif
    state_t state;
    logic [PORT_BITS-1:0] grant, rr_ptr, pick, cand, next_ptr;
    logic found, in_busy, beat, wd_abort;

    assign in_busy = state == BUSY;
    assign beat = out_valid & out_ready;
    assign next_ptr = grant == PORT_BITS'(NUM_PORTS - 1) ? '0 : grant + 1'b1;
    assign out_port = grant;
    assign out_abort = wd_abort;
    assign out_valid = in_busy ? in_valid[grant] : wd_abort;
    assign out_last = in_busy ? in_last[grant] : wd_abort;
    assign out_data = in_busy ? in_data[grant*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign in_ready = in_busy ? NUM_PORTS'(out_ready) << grant : '0;

    // Scan downward so the lowest offset from rr_ptr wins.
    always_comb begin
        pick = '0;
        cand = '0;
        found = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            cand = PORT_BITS'((int'(rr_ptr) + i) % NUM_PORTS);
            if (frame_ready[cand]) begin
                pick = cand;
                found = 1'b1;
            end
        end
    end

`ifdef FABRIC_ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] stall_cnt;
    logic stall_hit;

    assign wd_abort = state == ABORT;
    assign stall_hit = in_busy && !in_valid[grant] && stall_cnt == CW'(TIMEOUT - 1);

    // Only an empty source counts as a stall; fabric back-pressure never does.
    always_ff @(posedge clk_fabric or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (state == IDLE || beat)
            stall_cnt <= '0;
        else if (in_busy && !in_valid[grant] && stall_cnt != CW'(TIMEOUT))
            stall_cnt <= stall_cnt + 1'b1;
    end
`else
    assign wd_abort = 1'b0;
`endif

    // The abort beat also carries out_last, so one path returns to IDLE for both.
    always_ff @(posedge clk_fabric or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            rr_ptr <= '0;
            busy <= 1'b0;
        end else if (state == IDLE) begin
            if (found) begin
                grant <= pick;
                busy <= 1'b1;
                state <= BUSY;
            end
        end else if (beat && out_last) begin
            state <= IDLE;
            busy <= 1'b0;
            rr_ptr <= next_ptr;
        end
`ifdef FABRIC_ARB_WATCHDOG_EN
        else if (stall_hit) begin
            state <= ABORT;
        end
`endif
    end
endmodule

// File: tb/tb_fabric_ingress_arbiter.sv
// tb_fabric_ingress_arbiter: scoreboard bench for fabric_ingress_arbiter; watchdog case needs FABRIC_ARB_WATCHDOG_EN
module tb_fabric_ingress_arbiter;
    localparam int NP = 24;
    localparam int DW = 32;
    localparam int PB = $clog2(NP);

    logic clk_fabric = 1'b0;
    logic rst = 1'b1;
    logic [NP-1:0] frame_ready, in_valid, in_last, in_ready;
    logic [NP*DW-1:0] in_data;
    logic out_valid, out_ready, out_last, out_abort, busy;
    logic [DW-1:0] out_data;
    logic [PB-1:0] out_port;

    typedef struct packed {
        logic [PB-1:0] port;
        logic [DW-1:0] data;
        logic last;
        logic abort;
    } exp_t;

    exp_t sb[$];
    logic [DW:0] src_q[NP][$];
    int passed = 0, total = 0, cyc = 0, acc_cnt = 0, last_acc_cyc = 0, wd_gap = 0;
    bit bp = 1'b0, prev_last = 1'b0, prev_pend = 1'b0;

    fabric_ingress_arbiter #(
        .NUM_PORTS(NP),
`ifdef FABRIC_ARB_WATCHDOG_EN
        .TIMEOUT(16),
`endif
        .DATA_WIDTH(DW)
    ) dut (
        .clk_fabric(clk_fabric),
        .rst(rst),
        .frame_ready(frame_ready),
        .in_valid(in_valid),
        .in_last(in_last),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .out_abort(out_abort),
        .out_port(out_port),
        .busy(busy)
    );

    always #5 clk_fabric = ~clk_fabric;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic load(int p, int n, bit term);
        for (int b = 0; b < n; b++) begin
            exp_t e;
            e.port = PB'(p);
            e.data = $urandom;
            e.last = term && b == n - 1;
            e.abort = 1'b0;
            src_q[p].push_back({e.last, e.data});
            sb.push_back(e);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            frame_ready[p] = src_q[p].size() > 0;
            in_valid[p] = frame_ready[p];
            in_last[p] = 1'b0;
            in_data[p*DW +: DW] = '0;
            if (frame_ready[p]) begin
                in_last[p] = src_q[p][0][DW];
                in_data[p*DW +: DW] = src_q[p][0][DW-1:0];
            end
        end
        out_ready = bp ? ~out_ready : 1'b1;
    endtask

    task automatic monitor();
        exp_t e;
        logic [NP-1:0] exp_ir;
        if (prev_pend) check("regrant", 64'(busy), 1);
        if (prev_last) check("idle_gap", 64'(busy), 0);
        exp_ir = (busy && !out_abort) ? NP'(out_ready) << out_port : '0;
        check("in_ready", 64'(in_ready), 64'(exp_ir));
        if (!busy) check("idle_valid", 64'(out_valid), 0);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", 1, 0);
            end else begin
                e = sb.pop_front();
                check("port", 64'(out_port), 64'(e.port));
                check("data", 64'(out_data), 64'(e.data));
                check("last", 64'(out_last), 64'(e.last));
                check("abort", 64'(out_abort), 64'(e.abort));
            end
            if (out_abort) wd_gap = cyc - last_acc_cyc;
            last_acc_cyc = cyc;
            acc_cnt++;
        end
        for (int p = 0; p < NP; p++)
            if (in_valid[p] && in_ready[p]) void'(src_q[p].pop_front());
        prev_last = out_valid && out_ready && out_last;
        prev_pend = !rst && !busy && (|frame_ready);
    endtask

    task automatic cycle();
        @(negedge clk_fabric);
        cyc++;
        drive();
        #1;
        monitor();
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 2000) begin
            cycle();
            n++;
        end
        check("drain", 64'(sb.size()), 0);
        cycle();
    endtask

    initial begin
        int start, n;
        frame_ready = '0;
        in_valid = '0;
        in_last = '0;
        in_data = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk_fabric);
        #1;
        check("rst_busy", 64'(busy), 0);
        check("rst_valid", 64'(out_valid), 0);
        check("rst_in_ready", 64'(in_ready), 0);
        check("rst_last", 64'(out_last), 0);
        check("rst_abort", 64'(out_abort), 0);
        check("rst_port", 64'(out_port), 0);
        check("rst_data", 64'(out_data), 0);
        rst = 1'b0;
        repeat (100) begin
            cycle();
            check("idle_busy", 64'(busy), 0);
        end
        for (int r = 0; r < 2; r++) begin
            load(0, 2, 1'b1);
            load(7, 2, 1'b1);
            load(23, 2, 1'b1);
        end
        drain();
        load(5, 4, 1'b1);
        drain();
        load(6, 2, 1'b1);
        load(4, 2, 1'b1);
        drain();
        bp = 1'b1;
        load(3, 8, 1'b1);
        drain();
        bp = 1'b0;
        load(2, 2, 1'b0);
        repeat (3) cycle();
`ifdef FABRIC_ARB_WATCHDOG_EN
        sb.push_back('{port: PB'(2), data: '0, last: 1'b1, abort: 1'b1});
        load(9, 3, 1'b1);
        drain();
        check("wd_gap", 64'(wd_gap), 17);
`else
        repeat (40) cycle();
        check("hold_busy", 64'(busy), 1);
        check("hold_port", 64'(out_port), 2);
        check("hold_valid", 64'(out_valid), 0);
        load(2, 1, 1'b1);
        drain();
`endif
        load(10, 6, 1'b1);
        start = acc_cnt;
        n = 0;
        while (acc_cnt - start < 2 && n < 200) begin
            cycle();
            n++;
        end
        check("midframe_wait", 64'(acc_cnt - start), 2);
        @(negedge clk_fabric);
        drive();
        rst = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 0);
        check("midrst_valid", 64'(out_valid), 0);
        check("midrst_in_ready", 64'(in_ready), 0);
        for (int p = 0; p < NP; p++) src_q[p].delete();
        sb.delete();
        prev_last = 1'b0;
        prev_pend = 1'b0;
        repeat (2) cycle();
        rst = 1'b0;
        load(2, 2, 1'b1);
        load(15, 2, 1'b1);
        drain();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
